escribir_blanco_mem: RTL and testbench



---
 rtl/escribir_blanco_mem_pkg.sv | 26 ++
 rtl/escribir_blanco_mem_contador_timeout.sv | 29 ++
 rtl/escribir_blanco_mem.sv | 125 ++++++++++++
 tb/tb_escribir_blanco_mem.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/escribir_blanco_mem_pkg.sv
// rtl/escribir_blanco_mem_pkg.sv - shared state encodings, widths and helpers for the white-fill datapath
package escribir_blanco_mem_pkg;

    // State encodings shared with the white-fill controller
    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_WAIT_ACK = 2'b01,
        ST_CLR_PEND = 2'b11
    } state_t;

    // Width of the published pixel cursor
    localparam int CURSOR_W = 24;

    // Production terminal count used by the controller
    localparam int NUM_PIXELS_PROD = 5000000;

    // Watchdog counter width, wide enough for any practical ack timeout
    localparam int WD_W = 16;

    // Unsigned check that the cursor has not yet reached the terminal count
    function automatic logic cursor_below(input logic [CURSOR_W-1:0] cursor,
                                          input logic [CURSOR_W-1:0] limit);
        return cursor < limit;
    endfunction

endpackage

// File: rtl/escribir_blanco_mem_contador_timeout.sv
// rtl/escribir_blanco_mem_contador_timeout.sv - clear/enable/limit counter raising hit on its final counted edge
module contador_timeout
    import escribir_blanco_mem_pkg::*;
#(
    parameter int W = WD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         hit
);

    logic [W-1:0] count;

    // hit is asserted during the edge on which the limit-th enabled edge is counted
    assign hit = en && (count == (limit - W'(1)));

    // Count enabled edges; clear takes priority over enable
    always_ff @(negedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && !hit) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/escribir_blanco_mem.sv
// rtl/escribir_blanco_mem.sv - white-fill framebuffer writer; optional ack watchdog under ESCRIBIR_BLANCO_TIMEOUT_EN
module escribir_blanco_mem
    import escribir_blanco_mem_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 24,
    parameter int NUM_PIXELS = 4,
    parameter int BASE_ADDR  = 0,
    parameter int TIMEOUT    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                plus,
    input  logic                out_rst,
    input  logic                mem_ack,
    output logic [CURSOR_W-1:0] cont_cursor,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_we,
    output logic                busy,
    output logic                err
);

    localparam logic [DATA_W-1:0]   WHITE = '1;
    localparam logic [CURSOR_W-1:0] LIMIT = CURSOR_W'(NUM_PIXELS);
    localparam logic [ADDR_W-1:0]   BASE  = ADDR_W'(BASE_ADDR);

    state_t state;
    logic   timeout_now;
    logic   blocked;

`ifdef ESCRIBIR_BLANCO_TIMEOUT_EN
    logic err_q;
    logic wd_clr;
    logic wd_en;

    // Watchdog restarts in IDLE, so every new issue begins from zero
    assign wd_clr = (state == ST_IDLE);
    assign wd_en  = (state != ST_IDLE);

    contador_timeout #(
        .W (WD_W)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .clr   (wd_clr),
        .en    (wd_en),
        .limit (WD_W'(TIMEOUT)),
        .hit   (timeout_now)
    );

    assign blocked = err_q;
    assign err     = err_q;
`else
    assign timeout_now = 1'b0;
    assign blocked     = 1'b0;
    assign err         = 1'b0;
`endif

    assign busy = (state != ST_IDLE);

    // Write FSM: issue one white pixel per plus, hold the request until ack
    always_ff @(negedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cont_cursor <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_we      <= 1'b0;
`ifdef ESCRIBIR_BLANCO_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (out_rst) begin
                        cont_cursor <= '0;
`ifdef ESCRIBIR_BLANCO_TIMEOUT_EN
                        err_q       <= 1'b0;
`endif
                    end else if (plus && !blocked && cursor_below(cont_cursor, LIMIT)) begin
                        mem_addr  <= BASE + ADDR_W'(cont_cursor);
                        mem_wdata <= WHITE;
                        mem_we    <= 1'b1;
                        state     <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (mem_ack) begin
                        // A clear arriving with the ack wins over the increment
                        cont_cursor <= out_rst ? '0 : cont_cursor + CURSOR_W'(1);
                        mem_we      <= 1'b0;
                        state       <= ST_IDLE;
                    end else if (timeout_now) begin
                        mem_we <= 1'b0;
`ifdef ESCRIBIR_BLANCO_TIMEOUT_EN
                        err_q  <= 1'b1;
`endif
                        state  <= ST_IDLE;
                    end else if (out_rst) begin
                        state <= ST_CLR_PEND;
                    end
                end
                ST_CLR_PEND: begin
                    if (mem_ack) begin
                        cont_cursor <= '0;
                        mem_we      <= 1'b0;
                        state       <= ST_IDLE;
                    end else if (timeout_now) begin
                        mem_we <= 1'b0;
`ifdef ESCRIBIR_BLANCO_TIMEOUT_EN
                        err_q  <= 1'b1;
`endif
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    mem_we <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_escribir_blanco_mem.sv
// tb/tb_escribir_blanco_mem.sv - directed self-checking bench for escribir_blanco_mem
module tb_escribir_blanco_mem;

    logic        clk;
    logic        rst;
    logic        plus;
    logic        out_rst;
    logic        mem_ack;
    logic [23:0] cont_cursor;
    logic [23:0] mem_addr;
    logic [23:0] mem_wdata;
    logic        mem_we;
    logic        busy;
    logic        err;

    int n_checks;
    int n_errors;

    escribir_blanco_mem #(
        .ADDR_W     (24),
        .DATA_W     (24),
        .NUM_PIXELS (4),
        .BASE_ADDR  (32'h100),
        .TIMEOUT    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .plus        (plus),
        .out_rst     (out_rst),
        .mem_ack     (mem_ack),
        .cont_cursor (cont_cursor),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .busy        (busy),
        .err         (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one active (falling) edge and settle before sampling
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        plus     = 1'b0;
        out_rst  = 1'b0;
        mem_ack  = 1'b0;

        // Reset state
        tick();
        chk("rst_cursor", 32'(cont_cursor), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        rst     = 1'b0;
        out_rst = 1'b1;
        tick();
        chk("clr_cursor", 32'(cont_cursor), 32'd0);
        chk("clr_we", 32'(mem_we), 32'd0);
        out_rst = 1'b0;

        // Full sweep: plus and ack held, two edges per pixel
        plus    = 1'b1;
        mem_ack = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k % 2 == 1) begin
                chk("sweep_we_hi", 32'(mem_we), 32'd1);
                chk("sweep_addr", 32'(mem_addr), 32'h100 + 32'((k - 1) / 2));
                chk("sweep_data", 32'(mem_wdata), 32'hFF_FFFF);
            end else begin
                chk("sweep_we_lo", 32'(mem_we), 32'd0);
                chk("sweep_cursor", 32'(cont_cursor), 32'(k / 2));
            end
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("sat_we", 32'(mem_we), 32'd0);
            chk("sat_cursor", 32'(cont_cursor), 32'd4);
        end

        // Clear back to zero
        plus    = 1'b0;
        mem_ack = 1'b0;
        out_rst = 1'b1;
        tick();
        chk("clr2_cursor", 32'(cont_cursor), 32'd0);
        out_rst = 1'b0;

        // Delayed ack: request held for 3 extra edges
        plus = 1'b1;
        tick();
        chk("dly_issue_we", 32'(mem_we), 32'd1);
        chk("dly_issue_addr", 32'(mem_addr), 32'h100);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("dly_hold_we", 32'(mem_we), 32'd1);
            chk("dly_hold_addr", 32'(mem_addr), 32'h100);
            chk("dly_hold_cursor", 32'(cont_cursor), 32'd0);
            chk("dly_hold_busy", 32'(busy), 32'd1);
        end
        plus    = 1'b0;
        mem_ack = 1'b1;
        tick();
        chk("dly_done_we", 32'(mem_we), 32'd0);
        chk("dly_done_cursor", 32'(cont_cursor), 32'd1);
        mem_ack = 1'b0;

        // plus dropped while waiting: write still completes, no re-issue
        plus = 1'b1;
        tick();
        chk("pd_issue_addr", 32'(mem_addr), 32'h101);
        plus = 1'b0;
        tick();
        chk("pd_hold_we", 32'(mem_we), 32'd1);
        mem_ack = 1'b1;
        tick();
        chk("pd_done_we", 32'(mem_we), 32'd0);
        chk("pd_cursor", 32'(cont_cursor), 32'd2);
        mem_ack = 1'b0;
        tick();
        tick();
        chk("pd_idle_we", 32'(mem_we), 32'd0);
        chk("pd_idle_busy", 32'(busy), 32'd0);
        chk("pd_idle_cursor", 32'(cont_cursor), 32'd2);
        plus = 1'b1;
        tick();
        chk("pd_reissue_we", 32'(mem_we), 32'd1);
        chk("pd_reissue_addr", 32'(mem_addr), 32'h102);
        plus    = 1'b0;
        mem_ack = 1'b1;
        tick();
        chk("pd_cursor3", 32'(cont_cursor), 32'd3);
        mem_ack = 1'b0;

        // Mid-write clear: request held until ack, then cursor cleared
        plus = 1'b1;
        tick();
        chk("mc_issue_addr", 32'(mem_addr), 32'h103);
        plus    = 1'b0;
        out_rst = 1'b1;
        tick();
        chk("mc_pend_we", 32'(mem_we), 32'd1);
        chk("mc_pend_busy", 32'(busy), 32'd1);
        out_rst = 1'b0;
        tick();
        chk("mc_pend2_we", 32'(mem_we), 32'd1);
        chk("mc_pend2_addr", 32'(mem_addr), 32'h103);
        chk("mc_pend2_cursor", 32'(cont_cursor), 32'd3);
        mem_ack = 1'b1;
        tick();
        chk("mc_done_we", 32'(mem_we), 32'd0);
        chk("mc_done_cursor", 32'(cont_cursor), 32'd0);
        chk("mc_done_busy", 32'(busy), 32'd0);
        mem_ack = 1'b0;

        // Simultaneous ack and clear in WAIT_ACK
        plus = 1'b1;
        tick();
        chk("sim_issue_addr", 32'(mem_addr), 32'h100);
        plus    = 1'b0;
        mem_ack = 1'b1;
        out_rst = 1'b1;
        tick();
        chk("sim_we", 32'(mem_we), 32'd0);
        chk("sim_cursor", 32'(cont_cursor), 32'd0);
        chk("sim_busy", 32'(busy), 32'd0);
        mem_ack = 1'b0;
        out_rst = 1'b0;

        // Watchdog: no ack after issue
        plus = 1'b1;
        tick();
        chk("wd_issue_we", 32'(mem_we), 32'd1);
        plus = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("wd_wait_we", 32'(mem_we), 32'd1);
        end
        tick();
`ifdef ESCRIBIR_BLANCO_TIMEOUT_EN
        chk("wd_to_we", 32'(mem_we), 32'd0);
        chk("wd_to_err", 32'(err), 32'd1);
        chk("wd_to_busy", 32'(busy), 32'd0);
        chk("wd_to_cursor", 32'(cont_cursor), 32'd0);
        plus = 1'b1;
        tick();
        chk("wd_blocked_we", 32'(mem_we), 32'd0);
        chk("wd_blocked_err", 32'(err), 32'd1);
        plus    = 1'b0;
        out_rst = 1'b1;
        tick();
        chk("wd_clr_err", 32'(err), 32'd0);
        out_rst = 1'b0;
`else
        chk("wd_none_we", 32'(mem_we), 32'd1);
        chk("wd_none_err", 32'(err), 32'd0);
        mem_ack = 1'b1;
        tick();
        chk("wd_none_done_we", 32'(mem_we), 32'd0);
        chk("wd_none_cursor", 32'(cont_cursor), 32'd1);
        mem_ack = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
